// File: rtl/rst_seq.sv
// rst_seq: staged reset release sequencer.
// Waits for a filtered clock-manager lock. It then releases rst_out[0],
// rst_out[1], ... one stage at a time, STAGE_DLY cycles apart.
// Optional feature macro: RST_SEQ_LOCK_LOSS_EN. When it is defined, a lock
// drop after sequencing has begun forces a restart and sets lock_lost.
module rst_seq #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DLY   = 16,
  parameter int LOCK_FILTER = 8
) (
  input  logic                  clk,
  input  logic                  sync_rst,
  input  logic                  pll_locked,
  input  logic                  sw_rst,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  seq_done,
  output logic                  lock_lost
);

  localparam int LOCK_W  = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam int DLY_W   = (STAGE_DLY > 1)   ? $clog2(STAGE_DLY)   : 1;
  localparam int STAGE_W = (NUM_STAGES > 1)  ? $clog2(NUM_STAGES)  : 1;

  localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_FILTER - 1);
  localparam logic [DLY_W-1:0]   DLY_LAST   = DLY_W'(STAGE_DLY - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    DONE      = 2'd2
  } state_t;

  state_t                  r_state;
  logic [LOCK_W-1:0]       r_lock_cnt;
  logic [DLY_W-1:0]        r_dly_cnt;
  logic [STAGE_W-1:0]      r_stage;
  logic [NUM_STAGES-1:0]   r_rst;
  logic                    r_done;
  // A restart request is frozen for one cycle and executed on the next edge.
  // The execution edge is edge 0 of the new timeline, so lock filtering
  // starts one edge later. sync_rst also arms this flag, which makes the
  // first edge after sync_rst falls behave in the same way.
  logic                    r_pend;
  logic                    w_ll_trig;

`ifdef RST_SEQ_LOCK_LOSS_EN
  logic r_pend_ll;
  logic r_lock_lost;

  // Lock loss only matters once sequencing has begun
  assign w_ll_trig = (r_state != WAIT_LOCK) && !pll_locked;
  assign lock_lost = r_lock_lost;
`else
  assign w_ll_trig = 1'b0;
  assign lock_lost = 1'b0;
`endif

  // Sequencer FSM: restart handling, lock filter, staged release
  always_ff @(posedge clk) begin
    if (sync_rst || r_pend) begin
      r_state    <= WAIT_LOCK;
      r_lock_cnt <= '0;
      r_dly_cnt  <= '0;
      r_stage    <= '0;
      r_rst      <= '1;
      r_done     <= 1'b0;
      r_pend     <= sync_rst | sw_rst;
`ifdef RST_SEQ_LOCK_LOSS_EN
      r_pend_ll  <= 1'b0;
      if (sync_rst) begin
        r_lock_lost <= 1'b0;
      end else if (r_pend_ll) begin
        r_lock_lost <= 1'b1;
      end
`endif
    end else if (sw_rst || w_ll_trig) begin
      // Freeze the sequence so a coincident terminal count cannot release a stage
      r_pend <= 1'b1;
`ifdef RST_SEQ_LOCK_LOSS_EN
      r_pend_ll <= !sw_rst;
`endif
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          if (pll_locked) begin
            if (r_lock_cnt == LOCK_LAST) begin
              r_state    <= RELEASE;
              r_lock_cnt <= '0;
              r_dly_cnt  <= '0;
              r_stage    <= '0;
            end else begin
              r_lock_cnt <= r_lock_cnt + 1'b1;
            end
          end else begin
            r_lock_cnt <= '0;
          end
        end
        RELEASE: begin
          if (r_dly_cnt == DLY_LAST) begin
            r_dly_cnt <= '0;
            // Shifting a zero in from bit 0 keeps rst_out thermometer-shaped
            r_rst     <= r_rst << 1;
            if (r_stage == STAGE_LAST) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_stage <= r_stage + 1'b1;
            end
          end else begin
            r_dly_cnt <= r_dly_cnt + 1'b1;
          end
        end
        DONE: begin
          r_done <= 1'b1;
        end
        default: begin
          r_state <= WAIT_LOCK;
        end
      endcase
    end
  end

  assign rst_out  = r_rst;
  assign seq_done = r_done;

endmodule

// File: tb/tb_rst_seq.sv
// Directed testbench for rst_seq. Instance u_dut uses the default parameters
// (4 stages, 16-cycle gap, 8-cycle lock filter). Instance u_min uses the
// minimum parameters (1 stage, 1-cycle gap, 1-cycle lock filter).
// Expected values are hand-derived edge numbers on the nominal timeline.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       sync_rst;
  logic       pll_locked;
  logic       sw_rst;
  logic [3:0] rst_out;
  logic       seq_done;
  logic       lock_lost;
  logic [0:0] m_rst_out;
  logic       m_seq_done;
  logic       m_lock_lost;

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = 0;

  rst_seq #(.NUM_STAGES(4), .STAGE_DLY(16), .LOCK_FILTER(8)) u_dut (
    .clk(clk), .sync_rst(sync_rst), .pll_locked(pll_locked), .sw_rst(sw_rst),
    .rst_out(rst_out), .seq_done(seq_done), .lock_lost(lock_lost)
  );

  rst_seq #(.NUM_STAGES(1), .STAGE_DLY(1), .LOCK_FILTER(1)) u_min (
    .clk(clk), .sync_rst(sync_rst), .pll_locked(pll_locked), .sw_rst(sw_rst),
    .rst_out(m_rst_out), .seq_done(m_seq_done), .lock_lost(m_lock_lost)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic go_to(input int n);
    while (edge_n < n) tick();
  endtask

  // Hold sync_rst, release it, and stop just after edge 0
  task automatic start_seq();
    sync_rst = 1'b1; sw_rst = 1'b0; pll_locked = 1'b1;
    repeat (3) tick();
    sync_rst = 1'b0;
    tick();
    edge_n = 0;
  endtask

  task automatic test_reset();
    sync_rst = 1'b1; sw_rst = 1'b0; pll_locked = 1'b0;
    repeat (3) tick();
    n_chk++; if (rst_out !== 4'hF) begin n_fail++; $display("FAIL reset_rst_out got=%h exp=f", rst_out); end
    n_chk++; if (seq_done !== 1'b0) begin n_fail++; $display("FAIL reset_seq_done got=%b exp=0", seq_done); end
    n_chk++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL reset_lock_lost got=%b exp=0", lock_lost); end
    n_chk++; if (m_rst_out !== 1'b1) begin n_fail++; $display("FAIL reset_min_rst got=%b exp=1", m_rst_out); end
  endtask

  task automatic test_nominal();
    int       ed [8] = '{0, 8, 23, 24, 40, 56, 71, 72};
    logic [3:0] er [8] = '{4'hF, 4'hF, 4'hF, 4'hE, 4'hC, 4'h8, 4'h8, 4'h0};
    logic     edn[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    start_seq();
    for (int i = 0; i < 8; i++) begin
      go_to(ed[i]);
      n_chk++; if (rst_out !== er[i]) begin n_fail++; $display("FAIL nominal_rst@%0d got=%h exp=%h", ed[i], rst_out, er[i]); end
      n_chk++; if (seq_done !== edn[i]) begin n_fail++; $display("FAIL nominal_done@%0d got=%b exp=%b", ed[i], seq_done, edn[i]); end
    end
  endtask

  task automatic test_lock_filter();
    start_seq();
    for (int n = 1; n <= 32; n++) begin
      pll_locked = (n == 8) ? 1'b0 : 1'b1;
      tick();
      if (n == 24 || n == 31) begin
        n_chk++; if (rst_out !== 4'hF) begin n_fail++; $display("FAIL filter_early@%0d got=%h exp=f", n, rst_out); end
      end
    end
    n_chk++; if (rst_out !== 4'hE) begin n_fail++; $display("FAIL filter_release@32 got=%h exp=e", rst_out); end
    pll_locked = 1'b1;
  endtask

  task automatic test_sw_restart();
    start_seq();
    go_to(44);
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    n_chk++; if (rst_out !== 4'hC) begin n_fail++; $display("FAIL sw_frozen@45 got=%h exp=c", rst_out); end
    tick();
    n_chk++; if (rst_out !== 4'hF) begin n_fail++; $display("FAIL sw_restart@46 got=%h exp=f", rst_out); end
    n_chk++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL sw_lock_lost@46 got=%b exp=0", lock_lost); end
    go_to(69);
    n_chk++; if (rst_out !== 4'hF) begin n_fail++; $display("FAIL sw_hold@69 got=%h exp=f", rst_out); end
    tick();
    n_chk++; if (rst_out !== 4'hE) begin n_fail++; $display("FAIL sw_rerelease@70 got=%h exp=e", rst_out); end
  endtask

  task automatic test_collision();
    start_seq();
    go_to(39);
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    n_chk++; if (rst_out !== 4'hE) begin n_fail++; $display("FAIL collide_no_release@40 got=%h exp=e", rst_out); end
    tick();
    n_chk++; if (rst_out !== 4'hF) begin n_fail++; $display("FAIL collide_restart@41 got=%h exp=f", rst_out); end
    go_to(64);
    n_chk++; if (rst_out !== 4'hF) begin n_fail++; $display("FAIL collide_hold@64 got=%h exp=f", rst_out); end
    tick();
    n_chk++; if (rst_out !== 4'hE) begin n_fail++; $display("FAIL collide_rerelease@65 got=%h exp=e", rst_out); end
  endtask

  task automatic test_lock_loss();
    start_seq();
    go_to(99);
    pll_locked = 1'b0;
    tick();
    n_chk++; if (rst_out !== 4'h0) begin n_fail++; $display("FAIL ll_sample@100 got=%h exp=0", rst_out); end
    tick();
`ifdef RST_SEQ_LOCK_LOSS_EN
    n_chk++; if (rst_out !== 4'hF) begin n_fail++; $display("FAIL ll_rst@101 got=%h exp=f", rst_out); end
    n_chk++; if (seq_done !== 1'b0) begin n_fail++; $display("FAIL ll_done@101 got=%b exp=0", seq_done); end
    n_chk++; if (lock_lost !== 1'b1) begin n_fail++; $display("FAIL ll_flag@101 got=%b exp=1", lock_lost); end
    go_to(110);
    pll_locked = 1'b1;
    go_to(130);
    n_chk++; if (lock_lost !== 1'b1) begin n_fail++; $display("FAIL ll_sticky@130 got=%b exp=1", lock_lost); end
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
    n_chk++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL ll_clear got=%b exp=0", lock_lost); end
`else
    n_chk++; if (rst_out !== 4'h0) begin n_fail++; $display("FAIL ll_ignored@101 got=%h exp=0", rst_out); end
    n_chk++; if (seq_done !== 1'b1) begin n_fail++; $display("FAIL ll_done@101 got=%b exp=1", seq_done); end
    n_chk++; if (lock_lost !== 1'b0) begin n_fail++; $display("FAIL ll_flag@101 got=%b exp=0", lock_lost); end
`endif
    pll_locked = 1'b1;
  endtask

  task automatic test_mid_reset();
    start_seq();
    go_to(49);
    sync_rst = 1'b1;
    tick();
    n_chk++; if (rst_out !== 4'hF) begin n_fail++; $display("FAIL mid_rst@50 got=%h exp=f", rst_out); end
    n_chk++; if (seq_done !== 1'b0) begin n_fail++; $display("FAIL mid_done@50 got=%b exp=0", seq_done); end
    sync_rst = 1'b0;
    tick();
    // Edge 51 is the new edge 0, so bit 0 falls at 51+24
    go_to(74);
    n_chk++; if (rst_out !== 4'hF) begin n_fail++; $display("FAIL mid_hold@74 got=%h exp=f", rst_out); end
    tick();
    n_chk++; if (rst_out !== 4'hE) begin n_fail++; $display("FAIL mid_release@75 got=%h exp=e", rst_out); end
  endtask

  task automatic test_min_params();
    start_seq();
    tick();
    n_chk++; if (m_rst_out !== 1'b1) begin n_fail++; $display("FAIL min_rst@1 got=%b exp=1", m_rst_out); end
    n_chk++; if (m_seq_done !== 1'b0) begin n_fail++; $display("FAIL min_done@1 got=%b exp=0", m_seq_done); end
    tick();
    n_chk++; if (m_rst_out !== 1'b0) begin n_fail++; $display("FAIL min_rst@2 got=%b exp=0", m_rst_out); end
    n_chk++; if (m_seq_done !== 1'b1) begin n_fail++; $display("FAIL min_done@2 got=%b exp=1", m_seq_done); end
  endtask

  initial begin
    sync_rst = 1'b1; sw_rst = 1'b0; pll_locked = 1'b0;
    test_reset();
    test_nominal();
    test_lock_filter();
    test_sw_restart();
    test_collision();
    test_lock_loss();
    test_mid_reset();
    test_min_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
